xa_initiator: RTL

Bus initiator for the X-side access port (`xa_*`) of `sif`. It drives `xa_wr_s`, `xa_rd_s`, `xa_addr` and `xa_data_wr`, and captures `xa_data_rd`. Commands enter through a valid/ready queue; read results leave through a valid/ready response queue. It is the reusable master that system logic and the testbench's active agent use to program and read back `sif`.

---
 rtl/xa_init_pkg.sv | 22 ++
 rtl/xa_initiator_if.sv | 34 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/xa_initiator.sv | 131 +++++++++++++
 4 files changed

// File: rtl/xa_init_pkg.sv
// Shared types for the X-side access port initiator: FSM state encoding and
// the command record at default widths.
package xa_init_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RD,
    GAP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } xa_cmd_t;

endpackage

// File: rtl/xa_initiator_if.sv
// Command/response queues and xa_* bus of the initiator. The master modport is
// the initiator's view; slave is the view of the command source and bus slave.
interface xa_initiator_if
  import xa_init_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic [DW-1:0] xa_data_rd;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, xa_data_rd,
    output cmd_ready, rsp_valid, rsp_rdata, xa_wr_s, xa_rd_s, xa_addr, xa_data_wr
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, xa_data_rd,
    input  cmd_ready, rsp_valid, rsp_rdata, xa_wr_s, xa_rd_s, xa_addr, xa_data_wr
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xa_initiator.sv
// Bus master for the xa_* port: queued commands are issued one at a time as
// single-cycle strobes; read data is returned through a response queue.
module xa_initiator
  import xa_init_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_b,
  xa_initiator_if.master bus,
  output logic          busy
);

  localparam int CMDW = 1 + AW + DW;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int LATW = $clog2(RD_LAT + 1);

  state_t          state_q;
  logic            ready_q;
  logic            wr_s_q;
  logic            rd_s_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [LATW-1:0] lat_q;

  logic [CMDW-1:0] cmd_head;
  logic            cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [CNTW-1:0] cmd_count;
  logic            head_we;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_wdata;

  logic            rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [CNTW-1:0] rsp_count;
  logic            rd_last;

  assign cmd_push = bus.cmd_valid && bus.cmd_ready;

  sync_fifo #(.WIDTH(CMDW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (cmd_push),
    .wdata_i ({bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  assign {head_we, head_addr, head_wdata} = cmd_head;

  // A read leaves the queue only when its response is guaranteed a slot;
  // everything behind it waits too, so ordering is preserved.
  assign cmd_pop  = (state_q == IDLE) && !cmd_empty
                    && (head_we || (rsp_count < CNTW'(DEPTH)));
  assign rd_last  = (lat_q == LATW'(RD_LAT - 1));
  assign rsp_push = (state_q == WAIT_RD) && rd_last;
  assign rsp_pop  = bus.rsp_valid && bus.rsp_ready;

  sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (rsp_push),
    .wdata_i (bus.xa_data_rd),
    .pop_i   (rsp_pop),
    .rdata_o (bus.rsp_rdata),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .count_o (rsp_count)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      wr_s_q  <= 1'b0;
      rd_s_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      wr_s_q  <= 1'b0;
      rd_s_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_pop) begin
            addr_q  <= head_addr;
            wdata_q <= head_wdata;
            if (head_we) begin
              state_q <= ISSUE_WR;
              wr_s_q  <= 1'b1;
            end else begin
              state_q <= ISSUE_RD;
              rd_s_q  <= 1'b1;
            end
          end
        end
        ISSUE_WR: state_q <= GAP;
        ISSUE_RD: begin
          state_q <= WAIT_RD;
          lat_q   <= '0;
        end
        WAIT_RD: begin
          if (rd_last) state_q <= IDLE;
          else         lat_q   <= lat_q + 1'b1;
        end
        GAP:      state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = ready_q && !cmd_full;
  assign bus.rsp_valid  = !rsp_empty;
  assign bus.xa_wr_s    = wr_s_q;
  assign bus.xa_rd_s    = rd_s_q;
  assign bus.xa_addr    = addr_q;
  assign bus.xa_data_wr = wdata_q;
  assign busy           = (cmd_count != '0) || (state_q != IDLE);

  a_rsp_room: assert property (@(posedge clk) disable iff (!rst_b)
    rsp_push |-> (!rsp_full || rsp_pop));
  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_b)
    !(wr_s_q && rd_s_q));

endmodule
